sync_fifo_rd_stream: RTL and testbench
======================================

// Module: sync_fifo_rd_stream
// PURPOSE
//   Read-side drain stage directly downstream of the synchronous FIFO.
//   Pops words from the FIFO (RD_EN/DATA_OUT/EMPTY, one-cycle registered read latency)
//   and presents them on a valid/ready master stream through a 2-entry skid buffer.
//   Sustains one word per cycle while the consumer holds M_READY high. Never over-reads the FIFO.
// PARAMETERS
//   FIFO_WIDTH  8   data width; must match the FIFO word width
//   CNT_WIDTH   16  width of the delivered-word counter XFER_CNT
// PORTS
//   CLK            in   1           clock; all state changes on rising edge
//   RST            in   1           reset, asynchronous, active-low
//   FIFO_EMPTY     in   1           FIFO EMPTY flag
//   FIFO_RD_EN     out  1           FIFO read strobe
//   FIFO_DATA_OUT  in   FIFO_WIDTH  FIFO read data; valid the cycle after FIFO_RD_EN
//   M_VALID        out  1           stream word available
//   M_READY        in   1           consumer accepts the word this cycle
//   M_DATA         out  FIFO_WIDTH  stream data, the head of the skid buffer
//   OCC            out  2           skid-buffer occupancy, 0..2
//   XFER_CNT       out  CNT_WIDTH   count of accepted stream words
// BEHAVIOUR
//   Reset (RST=0, async): OCC=0, M_VALID=0, M_DATA=0, XFER_CNT=0, FIFO_RD_EN=0, in-flight flag=0.
//     Any in-flight read is discarded. The FIFO shares RST, so there is no data loss at system level.
//   State: OCC FSM {ZERO, ONE, TWO}, plus register INFL (a read was issued last cycle).
//   pop     = M_VALID & M_READY
//   FIFO_RD_EN (combinational) = RST & ~FIFO_EMPTY & ((OCC + INFL - pop) < 2).
//     Lookahead guarantees the buffer never exceeds 2 entries.
//     FIFO_RD_EN is never asserted while FIFO_EMPTY=1.
//   INFL_next = FIFO_RD_EN. When INFL=1, FIFO_DATA_OUT is written at the tail at the rising edge.
//   OCC_next = OCC + INFL - pop. Transitions:
//     ZERO->ONE on capture.
//     ONE->TWO on capture & ~pop.
//     ONE->ZERO on pop & ~capture.
//     TWO->ONE on pop & ~capture.
//     Capture & pop together: OCC is unchanged, the head advances, the new word goes to the tail.
//     pop in ZERO cannot occur. Capture in TWO cannot occur; this is an assertion.
//   Entries leave in strict FIFO order. No word is duplicated or dropped.
//   M_VALID = (OCC != 0). M_DATA = head entry, registered.
//     M_DATA and M_VALID are stable while M_VALID & ~M_READY.
//   Latency: FIFO_EMPTY falls in cycle t with OCC=0, INFL=0 ->
//     FIFO_RD_EN=1 in cycle t, capture at the end of t+1, M_VALID=1 in cycle t+2.
//   Throughput: with M_READY held at 1, the steady state is OCC=1, INFL=1, one word per cycle.
//   Backpressure: after M_READY falls, at most 2 words are buffered, then FIFO_RD_EN=0.
//   XFER_CNT increments by 1 on each pop and wraps modulo 2^CNT_WIDTH with no saturation.
//   Reset mid-stream: all outputs return to reset values asynchronously.
//     Operation restarts cleanly on the first edge after release.
// TESTING
//   1 Reset: RST=0 with FIFO_EMPTY=0 and M_READY=1 ->
//     FIFO_RD_EN=0, M_VALID=0, OCC=0, XFER_CNT=0 throughout.
//   2 Single word: FIFO holds 0xA5, M_READY=1 -> RD_EN for 1 cycle,
//     M_VALID=1 with M_DATA=0xA5 two cycles later, XFER_CNT=1, then idle.
//   3 Streaming: 16 words 0x00..0x0F preloaded, M_READY=1 ->
//     16 consecutive M_VALID cycles, in order, no gaps, XFER_CNT=16.
//   4 Backpressure: stream 8 words, drop M_READY for 5 cycles mid-stream ->
//     OCC reaches 2, RD_EN=0 while stalled, M_DATA held, all 8 words delivered in order.
//   5 Empty boundary: FIFO empties while M_READY toggles 1/0 ->
//     no RD_EN while FIFO_EMPTY=1, no duplicated word, OCC returns to 0.
//   6 Reset mid-operation and wrap: assert RST with OCC=2 -> OCC=0 immediately.
//     Separately, CNT_WIDTH=4 with 17 words -> XFER_CNT=1.

Source files
------------

// File: rtl/sync_fifo_rd_stream_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of the FIFO drain stage.
interface sync_fifo_rd_stream_if #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  FIFO_EMPTY;
  logic                  FIFO_RD_EN;
  logic [FIFO_WIDTH-1:0] FIFO_DATA_OUT;
  logic                  M_VALID;
  logic                  M_READY;
  logic [FIFO_WIDTH-1:0] M_DATA;
  logic [1:0]            OCC;
  logic [CNT_WIDTH-1:0]  XFER_CNT;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA_OUT, M_READY,
    output FIFO_RD_EN, M_VALID, M_DATA, OCC, XFER_CNT
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA_OUT, M_READY,
    input  FIFO_RD_EN, M_VALID, M_DATA, OCC, XFER_CNT
  );
endinterface

// File: rtl/sync_fifo_rd_stream.sv
// FIFO drain stage: pops a registered-read FIFO and presents words on a valid/ready
// stream through a 2-entry skid buffer, counting every accepted word.
module sync_fifo_rd_stream #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  sync_fifo_rd_stream_if.master  bus
);

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } occ_e;

  occ_e                  state_q, state_d;
  logic                  infl_q, infl_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;

  logic       valid;
  logic       pop;
  logic       capture;
  logic       rd_en;
  logic [1:0] level;

  always_comb begin
    valid   = (state_q != ZERO);
    pop     = valid & bus.M_READY;
    capture = infl_q;
    // Occupancy once the in-flight word lands and this cycle's pop leaves; never exceeds 3.
    level   = 2'(state_q) + {1'b0, infl_q} - {1'b0, pop};
    rd_en   = RST & ~bus.FIFO_EMPTY & (level < 2'd2);
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    infl_d  = rd_en;
    xfer_d  = xfer_q;
    if (pop) begin
      xfer_d = xfer_q + 1'b1;
    end
    unique case (state_q)
      ZERO: begin
        if (capture) begin
          head_d  = bus.FIFO_DATA_OUT;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({capture, pop})
          2'b10: begin
            tail_d  = bus.FIFO_DATA_OUT;
            state_d = TWO;
          end
          2'b01: state_d = ZERO;
          2'b11: head_d  = bus.FIFO_DATA_OUT;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ZERO;
      infl_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      xfer_q  <= xfer_d;
    end
  end

  assign bus.FIFO_RD_EN = rd_en;
  assign bus.M_VALID    = valid;
  assign bus.M_DATA     = head_q;
  assign bus.OCC        = state_q;
  assign bus.XFER_CNT   = xfer_q;

  // The read lookahead must keep a landing word from ever meeting a full buffer.
  assert property (@(posedge CLK) disable iff (!RST) !(infl_q && state_q == TWO));

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Scoreboard bench for sync_fifo_rd_stream: a queue-based FIFO model feeds the DUT and
// a monitor compares every accepted stream word and occupancy against bookkeeping counts.
module tb_sync_fifo_rd_stream;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sync_fifo_rd_stream_if #(.FIFO_WIDTH(8), .CNT_WIDTH(16)) bus();
  sync_fifo_rd_stream_if #(.FIFO_WIDTH(8), .CNT_WIDTH(4))  bus4();

  sync_fifo_rd_stream #(.FIFO_WIDTH(8), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  sync_fifo_rd_stream #(.FIFO_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [7:0] fifo_m[$];
  logic [7:0] exp_q[$];

  bit          mon_en = 1'b0;
  int unsigned rd_total = 0;
  int unsigned deliv = 0;
  int unsigned pop_cnt = 0;
  bit          infl_m = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  int          occ_exp;
  bit          mon_pop;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void push(logic [7:0] w);
    fifo_m.push_back(w);
    exp_q.push_back(w);
  endfunction

  // Monitor: words that left the FIFO model more than one edge ago and are not yet
  // accepted must be sitting in the buffer; accepted words must match issue order.
  always @(negedge CLK) begin
    #2;
    if (RST && mon_en) begin
      occ_exp = int'(rd_total) - int'(infl_m) - int'(deliv);
      mon_pop = bus.M_VALID && bus.M_READY;
      check("occ", 32'(bus.OCC), 32'(occ_exp));
      check("valid", 32'(bus.M_VALID), 32'(occ_exp != 0));
      check("xfer_cnt", 32'(bus.XFER_CNT), pop_cnt & 32'hFFFF);
      if (bus.FIFO_EMPTY) check("rd_when_empty", 32'(bus.FIFO_RD_EN), 32'd0);
      if (prev_stall) begin
        check("hold_valid", 32'(bus.M_VALID), 32'd1);
        check("hold_data", 32'(bus.M_DATA), 32'(prev_data));
      end
      if (mon_pop) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(bus.M_DATA), 32'hFFFF_FFFF);
        else check("data_order", 32'(bus.M_DATA), 32'(exp_q.pop_front()));
        pop_cnt++;
        deliv++;
      end
      rd_total  += 32'(bus.FIFO_RD_EN);
      infl_m     = bus.FIFO_RD_EN;
      prev_stall = bus.M_VALID && !bus.M_READY;
      prev_data  = bus.M_DATA;
    end
  end

  // One clock of the FIFO model: inputs set on the falling edge, registered read data
  // appears just after the rising edge that follows a sampled read strobe.
  task automatic cycle(input bit rdy, output bit rd, output bit v,
                       output logic [7:0] d, output logic [1:0] occ);
    @(negedge CLK);
    bus.M_READY    = rdy;
    bus.FIFO_EMPTY = (fifo_m.size() == 0);
    #1;
    rd  = bus.FIFO_RD_EN;
    v   = bus.M_VALID;
    d   = bus.M_DATA;
    occ = bus.OCC;
    @(posedge CLK);
    #1;
    if (rd && fifo_m.size() != 0) bus.FIFO_DATA_OUT = fifo_m.pop_front();
    bus.FIFO_EMPTY = (fifo_m.size() == 0);
  endtask

  initial begin
    bit         rd, v, rd4;
    logic [7:0] d;
    logic [1:0] occ, max_occ;
    int         first, last, nvalid, n4;

    bus.FIFO_EMPTY    = 1'b0;
    bus.M_READY       = 1'b1;
    bus.FIFO_DATA_OUT = '0;
    bus4.FIFO_EMPTY    = 1'b1;
    bus4.M_READY       = 1'b0;
    bus4.FIFO_DATA_OUT = '0;

    // Held in reset with a non-empty FIFO and a ready consumer.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      check("rst_rd_en", 32'(bus.FIFO_RD_EN), 32'd0);
      check("rst_valid", 32'(bus.M_VALID), 32'd0);
      check("rst_occ", 32'(bus.OCC), 32'd0);
      check("rst_xfer", 32'(bus.XFER_CNT), 32'd0);
    end
    bus.FIFO_EMPTY = 1'b1;
    @(negedge CLK);
    RST    = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, rd, v, d, occ);

    // Single word: strobe in cycle t, word visible in t+2.
    push(8'hA5);
    cycle(1'b1, rd, v, d, occ);
    check("single_rd_t0", 32'(rd), 32'd1);
    check("single_valid_t0", 32'(v), 32'd0);
    cycle(1'b1, rd, v, d, occ);
    check("single_rd_t1", 32'(rd), 32'd0);
    check("single_valid_t1", 32'(v), 32'd0);
    cycle(1'b1, rd, v, d, occ);
    check("single_valid_t2", 32'(v), 32'd1);
    check("single_data_t2", 32'(d), 32'hA5);
    cycle(1'b1, rd, v, d, occ);
    check("single_idle_t3", 32'(v), 32'd0);
    check("single_xfer", 32'(bus.XFER_CNT), 32'd1);

    // Streaming: 16 back-to-back words.
    for (int w = 0; w < 16; w++) push(8'(w));
    first = -1; last = -1; nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, rd, v, d, occ);
      if (v) begin
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("stream_count", 32'(nvalid), 32'd16);
    check("stream_no_gap", 32'(last - first + 1), 32'd16);
    check("stream_xfer", 32'(bus.XFER_CNT), 32'd17);

    // Backpressure: 5 stalled cycles mid-stream.
    for (int w = 0; w < 8; w++) push(8'(8'h30 + w));
    max_occ = '0;
    for (int i = 0; i < 3; i++) cycle(1'b1, rd, v, d, occ);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, rd, v, d, occ);
      check("stall_rd_en", 32'(rd), 32'd0);
      if (occ > max_occ) max_occ = occ;
    end
    cycle(1'b1, rd, v, d, occ);
    if (occ > max_occ) max_occ = occ;
    check("stall_occ_max", 32'(max_occ), 32'd2);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle(1'b1, rd, v, d, occ);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Empty boundary with a toggling, random consumer.
    for (int w = 0; w < 3; w++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      if (i < 25 && $urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
      cycle(1'(i % 2 == 0 ? 1 : $urandom_range(0, 1)), rd, v, d, occ);
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle(1'b1, rd, v, d, occ);
    for (int i = 0; i < 3; i++) cycle(1'b1, rd, v, d, occ);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_occ_zero", 32'(occ), 32'd0);

    // Reset while the buffer is full.
    for (int w = 0; w < 8; w++) push(8'(8'h50 + w));
    for (int i = 0; i < 3; i++) cycle(1'b1, rd, v, d, occ);
    for (int i = 0; i < 3; i++) cycle(1'b0, rd, v, d, occ);
    check("pre_reset_occ", 32'(occ), 32'd2);
    #3;
    mon_en = 1'b0;
    RST    = 1'b0;
    #1;
    check("async_rst_occ", 32'(bus.OCC), 32'd0);
    check("async_rst_valid", 32'(bus.M_VALID), 32'd0);
    check("async_rst_data", 32'(bus.M_DATA), 32'd0);
    check("async_rst_xfer", 32'(bus.XFER_CNT), 32'd0);
    check("async_rst_rd_en", 32'(bus.FIFO_RD_EN), 32'd0);
    fifo_m.delete();
    exp_q.delete();
    rd_total = 0; deliv = 0; pop_cnt = 0;
    infl_m = 1'b0; prev_stall = 1'b0;
    bus.FIFO_EMPTY = 1'b1;
    @(negedge CLK);
    RST    = 1'b1;
    mon_en = 1'b1;
    for (int w = 0; w < 4; w++) push(8'(8'h60 + w));
    for (int i = 0; i < 12; i++) cycle(1'b1, rd, v, d, occ);
    check("restart_drained", 32'(exp_q.size()), 32'd0);
    check("restart_xfer", 32'(bus.XFER_CNT), 32'd4);

    // Counter wrap: 17 words through a 4-bit counter.
    n4 = 17;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      bus4.FIFO_EMPTY = (n4 == 0);
      bus4.M_READY    = 1'b1;
      #1;
      rd4 = bus4.FIFO_RD_EN;
      @(posedge CLK);
      #1;
      if (rd4 && n4 > 0) n4--;
      bus4.FIFO_DATA_OUT = 8'(i);
      bus4.FIFO_EMPTY    = (n4 == 0);
    end
    check("wrap_fifo_drained", 32'(n4), 32'd0);
    check("wrap_valid_idle", 32'(bus4.M_VALID), 32'd0);
    check("wrap_xfer", 32'(bus4.XFER_CNT), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
